// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock supervisor releasing video reset after stable lock; optional phase stepping under PLL_PHASE_ADJ_EN
module pll_lock_sequencer #(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 7,
   parameter int CNT_W               = 17,
   parameter int RETRY_W             = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
`ifdef PLL_PHASE_ADJ_EN
   input  logic               phase_req,
   input  logic               phase_dir,
   input  logic [1:0]         phase_sel,
   output logic               phase_busy,
   output logic [1:0]         pll_phasesel,
   output logic               pll_phasedir,
   output logic               pll_phasestep,
`endif
   output logic               pll_rst,
   output logic               video_rst,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [2:0]         state_dbg
);
   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;
   localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       timer_q, timer_d;
   logic [RETRY_W-1:0]     retry_q, retry_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   pll_rst_q, pll_rst_d, video_rst_q, video_rst_d;
   logic                   ready_q, ready_d, fault_q, fault_d;
   logic                   lock_s, retry_go;
   assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
   assign lock_s = sync_q[SYNC_STAGES-1];
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RESET_PLL;
         timer_q     <= '0;
         retry_q     <= '0;
         sync_q      <= '0;
         pll_rst_q   <= 1'b1;
         video_rst_q <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         sync_q      <= sync_d;
         pll_rst_q   <= pll_rst_d;
         video_rst_q <= video_rst_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + CNT_W'(1);
      retry_d  = retry_q;
      retry_go = 1'b0;
      case (state_q)
         RESET_PLL: if (timer_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
         end
         WAIT_LOCK: if (lock_s) begin
            state_d = STABILIZE;
            timer_d = '0;
         end else if (timer_q == TO_LAST) retry_go = 1'b1;
         STABILIZE: if (!lock_s) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
         end else if (timer_q == STB_LAST) begin
            state_d = RUN;
            timer_d = '0;
         end
         RUN: begin
            timer_d  = '0;
            retry_go = !lock_s;
         end
         FAULT: timer_d = '0;
         default: begin
            state_d = RESET_PLL;
            timer_d = '0;
         end
      endcase
      // Exhausted retries park in FAULT; the counter never advances past the limit
      if (retry_go) begin
         state_d = (retry_q == RETRY_MAX) ? FAULT : RESET_PLL;
         retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);
         timer_d = '0;
      end
   end
   always_comb begin
      pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
      video_rst_d = state_d != RUN;
      ready_d     = state_d == RUN;
      fault_d     = state_d == FAULT;
   end
   assign pll_rst   = pll_rst_q;
   assign video_rst = video_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign state_dbg = state_q;
`ifdef PLL_PHASE_ADJ_EN
   logic       busy_q, busy_d, step_q, step_d, dir_q, dir_d, accept;
   logic [1:0] sel_q, sel_d;
   logic [3:0] ph_q, ph_d;
   always_comb begin
      accept = ready_q && !busy_q && phase_req;
      ph_d   = accept ? 4'd0 : busy_q ? ph_q + 4'd1 : ph_q;
      sel_d  = accept ? phase_sel : sel_q;
      dir_d  = accept ? phase_dir : dir_q;
      busy_d = (state_d == RUN) && (accept || (busy_q && ph_q != 4'd8));
      step_d = !(busy_d && ph_d >= 4'd1 && ph_d <= 4'd4);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         step_q <= 1'b1;
         dir_q  <= 1'b1;
         sel_q  <= 2'd0;
         ph_q   <= 4'd0;
      end else begin
         busy_q <= busy_d;
         step_q <= step_d;
         dir_q  <= dir_d;
         sel_q  <= sel_d;
         ph_q   <= ph_d;
      end
   end
   assign phase_busy    = busy_q;
   assign pll_phasestep = step_q;
   assign pll_phasedir  = dir_q;
   assign pll_phasesel  = sel_q;
`endif
endmodule
